ni_axil_responder: RTL

AXI4-Lite slave that terminates the network interface's AXI4-Lite master transactions and bridges them to the router side of the NoC. Writes to the data register push words into a TX FIFO that drains toward the router. Reads of the data register pop words the router has delivered into an RX FIFO. A read-only status register exposes FIFO occupancy, and every access gets a defined OKAY, SLVERR or DECERR response.

---
 rtl/ni_axil_responder.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ni_axil_responder.sv
// ni_axil_responder
//   AXI4-Lite slave bridging the network interface to the NoC router.
//   DATA   (BASE_ADDR+0): write pushes into the TX FIFO, read pops the RX FIFO.
//   STATUS (BASE_ADDR+4): read-only {8'h0, rx_count, tx_count, 6'h0, rx_empty, tx_full}.
//   Responses: OKAY, SLVERR (full/empty/read-only/bad strobe), DECERR (undecoded).
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   aw*/w*/b*                     AXI4-Lite write address/data/response channels
//   ar*/r*                        AXI4-Lite read address/data channels
//   tx_data/tx_valid/tx_ready     TX FIFO head toward the router
//   rx_data/rx_valid/rx_ready     router words into the RX FIFO
//   wstrb                         present only when NI_RESP_STRB_EN is defined;
//                                 DATA writes need all four lanes enabled
//
// Parameters
//   BASE_ADDR  base of the 8-byte register window
//   DEPTH      entries per FIFO, power of two in 2..128
module ni_axil_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
`ifdef NI_RESP_STRB_EN
  input  logic [3:0]  wstrb,
`endif
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned PW          = $clog2(DEPTH);
  localparam logic [7:0]  DEPTH_CNT   = 8'(DEPTH);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic        aw_held_q, aw_held_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic [31:0] wdata_q,   wdata_d;
`ifdef NI_RESP_STRB_EN
  logic [3:0]  wstrb_q,   wstrb_d;
`endif
  logic [1:0]  bresp_q,   bresp_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;

  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [7:0]    tx_count_q,  tx_count_d,  rx_count_q,  rx_count_d;
  logic [31:0]   tx_mem_q [DEPTH];
  logic [31:0]   rx_mem_q [DEPTH];

  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;
  logic        wr_is_data, wr_is_status, strb_ok;
  logic        rd_is_data, rd_is_status;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_word;

  // All full/empty decisions use pre-edge counts.
  assign tx_full  = (tx_count_q == DEPTH_CNT);
  assign tx_empty = (tx_count_q == 8'd0);
  assign rx_full  = (rx_count_q == DEPTH_CNT);
  assign rx_empty = (rx_count_q == 8'd0);

  assign awready  = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready   = (w_state_q == W_IDLE) && !w_held_q;
  assign bvalid   = (w_state_q == W_RESP);
  assign bresp    = bresp_q;
  assign arready  = (r_state_q == R_IDLE);
  assign rvalid   = (r_state_q == R_RESP);
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign rx_ready = !rx_full;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // The access fires on the edge that completes the later of AW/W, so a
  // channel arriving this cycle is taken straight from the bus.
  assign wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q  ? wdata_q  : wdata;
`ifdef NI_RESP_STRB_EN
  assign strb_ok = ((w_held_q ? wstrb_q : wstrb) == 4'hF);
`else
  assign strb_ok = 1'b1;
`endif
  assign wr_is_data   = (wr_addr == BASE_ADDR);
  assign wr_is_status = (wr_addr == STATUS_ADDR);
  assign rd_is_data   = (araddr == BASE_ADDR);
  assign rd_is_status = (araddr == STATUS_ADDR);

  assign tx_push = wr_fire && wr_is_data && strb_ok && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = ar_hs && rd_is_data && !rx_empty;

  always_comb begin
    wr_resp = RESP_DECERR;
    if (wr_is_data) begin
      wr_resp = (strb_ok && !tx_full) ? RESP_OKAY : RESP_SLVERR;
    end else if (wr_is_status) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_DECERR;
    if (rd_is_data) begin
      if (!rx_empty) begin
        rd_word = rx_mem_q[rx_rd_ptr_q];
        rd_resp = RESP_OKAY;
      end else begin
        rd_resp = RESP_SLVERR;
      end
    end else if (rd_is_status) begin
      rd_word = {8'h00, rx_count_q, tx_count_q, 6'h00, rx_empty, tx_full};
      rd_resp = RESP_OKAY;
    end
  end

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
`ifdef NI_RESP_STRB_EN
    wstrb_d   = wstrb_q;
`endif
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
`ifdef NI_RESP_STRB_EN
          wstrb_d  = wstrb;
`endif
        end
        if (wr_fire) begin
          w_state_d = W_RESP;
          bresp_d   = wr_resp;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_RESP;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FIFO pointers and counts; simultaneous push/pop leaves the count unchanged.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + PW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + PW'(tx_pop);
    tx_count_d  = tx_count_q + {7'd0, tx_push} - {7'd0, tx_pop};
    rx_wr_ptr_d = rx_wr_ptr_q + PW'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + PW'(rx_pop);
    rx_count_d  = rx_count_q + {7'd0, rx_push} - {7'd0, rx_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
`ifdef NI_RESP_STRB_EN
      wstrb_q     <= '0;
`endif
      bresp_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
`ifdef NI_RESP_STRB_EN
      wstrb_q     <= wstrb_d;
`endif
      bresp_q     <= bresp_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  // Storage is not reset; reset empties the FIFOs through the pointers/counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wr_data;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
  end

endmodule
